max_pool_2x2: RTL and testbench
===============================

// Module: max_pool_2x2
// PURPOSE
//  Stream-side consumer of the activation stage: takes the ce-qualified pixel stream leaving ReLU
//  (row-major, one pixel per ce cycle) and emits one 2x2/stride-2 pooled value per window.
//  Sits between activation and the next conv layer / FC input buffer; output uses the same ce-qualified format.
// PARAMETERS
//  BIT_WIDTH  32  pixel width, two's complement
//  IMG_W      24  input feature-map width in pixels; must be even, >=2
//  IMG_H      24  input feature-map height in pixels; must be even, >=2
// PORTS
//  clk           in   1          clock, rising edge
//  global_rst_n  in   1          reset, asynchronous, active-low
//  rst           in   1          synchronous clear; same effect as reset, no effect on line-buffer contents
//  ce            in   1          i_data valid this cycle
//  i_data        in   BIT_WIDTH  input pixel
//  o_data        out  BIT_WIDTH  pooled value; 0 whenever o_ce=0
//  o_ce          out  1          one-cycle pulse, o_data valid
//  o_frame_done  out  1          pulses together with o_ce for the last window of a frame
// BEHAVIOUR
//  - Reset (global_rst_n=0 or rst=1): col=0, row=0, r_h=0, o_data=0, o_ce=0, o_frame_done=0.
//  - Counters col (0..IMG_W-1), row (0..IMG_H-1) advance only on ce; ce gaps of any length hold all state.
//  - col even: r_h <= i_data.  col odd: h = max(r_h, i_data) (signed compare).
//  - row even & col odd: line_buf[col>>1] <= h; no output.
//  - row odd & col odd: o_data <= max(line_buf[col>>1], h); o_ce <= 1 on the next edge (latency 1 cycle
//    from the ce of the window's bottom-right pixel). All other cycles: o_ce <= 0, o_data <= 0.
//  - col wraps IMG_W-1 -> 0 with row+1; row wraps IMG_H-1 -> 0 at frame end; next frame starts with no
//    idle cycle needed (back-to-back ce across frames legal).
//  - o_frame_done <= 1 with the window at row=IMG_H-1, col=IMG_W-1; else 0.
//  - Output count per frame: exactly (IMG_W/2)*(IMG_H/2).
//  - Reset mid-frame: partial window discarded; next ce is treated as pixel (0,0). Stale line_buf never
//    read: every entry is rewritten on an even row before its odd-row read.
//  - Ties: equal values give that value; no sign/width change (max output is BIT_WIDTH, exact).
// CONFIGURATION
//  MAX_POOL_AVG_EN defined: average pooling instead of max. Horizontal stage stores sum r_h+i_data
//   (BIT_WIDTH+1, sign-extended), line_buf widens to BIT_WIDTH+1, final sum is BIT_WIDTH+2 bits,
//   o_data = (sum >>> 2) truncated to BIT_WIDTH (floor toward -inf). Timing/handshake identical.
//  Not defined: max pooling as above.
// STRUCTURE
//  - pool_pkg: localparams COL_W=$clog2(IMG_W), ROW_W=$clog2(IMG_H), LB_DEPTH=IMG_W/2, accumulator
//    width function (BIT_WIDTH or BIT_WIDTH+1 per MAX_POOL_AVG_EN), signed max function.
//  - Sub-module pool_line_buf: LB_DEPTH x width register array, one sync write port, one combinational
//    read port, no reset on storage. Top holds counters, r_h, compare/average and output registers.
// TESTING
//  1 Reset: global_rst_n low mid-stream -> o_ce=0, o_data=0 immediately; first ce after release is pixel (0,0).
//  2 IMG_W=IMG_H=4, pixels 0..15 continuous ce -> o_ce pulses 4x with 5,7,13,15, each 1 cycle after
//    pixels 5,7,13,15's ce; o_frame_done only with 15.
//  3 Same frame with random ce gaps (ce ~40%) -> identical output sequence, no extra/missing pulses.
//  4 Signed: window {-8,-3,-20,-1} -> o_data=-1; window {0,0,0,0} -> o_data=0 with o_ce=1.
//  5 Two back-to-back frames, rst pulse after 6 pixels of frame 2 -> frame 2 restarted cleanly, 4 outputs.
//  6 MAX_POOL_AVG_EN: window {1,2,3,5} -> 2; {-1,-2,-1,-1} -> -2; {MAX,MAX,MAX,MAX} -> MAX (no overflow).

Source files
------------

// File: rtl/max_pool_2x2_pkg.sv
// max_pool_2x2_pkg: shared sizing helpers and signed max for the 2x2 pooling stage
// No ports. acc_w gives the horizontal/line-buffer width (widened by one bit when MAX_POOL_AVG_EN is defined).
package max_pool_2x2_pkg;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int lb_depth(input int img_w);
    return img_w / 2;
  endfunction
  function automatic int acc_w(input int bw);
`ifdef MAX_POOL_AVG_EN
    return bw + 1;
`else
    return bw;
`endif
  endfunction
  function automatic logic signed [63:0] smax(input logic signed [63:0] a, input logic signed [63:0] b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/max_pool_2x2_if.sv
// max_pool_2x2_if: ce-qualified pixel stream in, pooled stream out
// Signals: ce, i_data (producer -> pool); o_data, o_ce, o_frame_done (pool -> consumer).
// Modports: master = stream producer/consumer side, slave = pooling block.
interface max_pool_2x2_if #(parameter int BIT_WIDTH = 32);
  logic ce;
  logic signed [BIT_WIDTH-1:0] i_data;
  logic signed [BIT_WIDTH-1:0] o_data;
  logic o_ce;
  logic o_frame_done;
  modport master(output ce, i_data, input o_data, o_ce, o_frame_done);
  modport slave(input ce, i_data, output o_data, o_ce, o_frame_done);
endinterface

// File: rtl/max_pool_2x2_line_buf.sv
// max_pool_2x2_line_buf: one row of horizontal results, held between the even and odd rows
// Ports: clk; we/waddr/wdata sync write port; raddr/rdata combinational read port. Storage has no reset.
module max_pool_2x2_line_buf #(
  parameter int W = 32,
  parameter int DEPTH = 12,
  parameter int AW = 4
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic signed [W-1:0] wdata,
  input  logic [AW-1:0]       raddr,
  output logic signed [W-1:0] rdata
);
  logic signed [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/max_pool_2x2.sv
// max_pool_2x2: 2x2 stride-2 pooling of a row-major ce-qualified pixel stream
// Ports: clk; global_rst_n async active-low reset; rst sync clear (line buffer untouched);
//   bus (slave): ce/i_data in, o_data/o_ce/o_frame_done out, one cycle after the window's last pixel.
// Build option: define MAX_POOL_AVG_EN for floor-average pooling instead of signed max.
module max_pool_2x2
  import max_pool_2x2_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int IMG_W = 24,
  parameter int IMG_H = 24
) (
  input logic             clk,
  input logic             global_rst_n,
  input logic             rst,
  max_pool_2x2_if.slave   bus
);
  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H);
  localparam int LB_DEPTH = lb_depth(IMG_W);
  localparam int LB_AW = cnt_w(LB_DEPTH);
  localparam int AW = acc_w(BIT_WIDTH);
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic signed [BIT_WIDTH-1:0] rh_q, rh_d, o_data_q, o_data_d, win;
  logic o_ce_q, o_ce_d, o_fd_q, o_fd_d;
  logic signed [AW-1:0] h, lb_rd;
  logic lb_we, col_last, row_last;
  logic [LB_AW-1:0] lb_addr;
  assign col_last = col_q == COL_W'(IMG_W - 1);
  assign row_last = row_q == ROW_W'(IMG_H - 1);
  assign lb_addr = LB_AW'(col_q >> 1);
`ifdef MAX_POOL_AVG_EN
  localparam int SW = BIT_WIDTH + 2;
  logic signed [SW-1:0] sum;
  assign h = AW'(rh_q) + AW'(bus.i_data);
  assign sum = SW'(lb_rd) + SW'(h);
  assign win = BIT_WIDTH'(sum >>> 2);
`else
  assign h = AW'(smax(64'(rh_q), 64'(bus.i_data)));
  assign win = BIT_WIDTH'(smax(64'(lb_rd), 64'(h)));
`endif
  max_pool_2x2_line_buf #(.W(AW), .DEPTH(LB_DEPTH), .AW(LB_AW)) u_lb (
    .clk(clk),
    .we(lb_we),
    .waddr(lb_addr),
    .wdata(h),
    .raddr(lb_addr),
    .rdata(lb_rd)
  );
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    rh_d = rh_q;
    lb_we = 1'b0;
    o_ce_d = 1'b0;
    o_data_d = '0;
    o_fd_d = 1'b0;
    if (rst) begin
      col_d = '0;
      row_d = '0;
      rh_d = '0;
    end else if (bus.ce) begin
      col_d = col_last ? '0 : col_q + 1'b1;
      row_d = !col_last ? row_q : row_last ? '0 : row_q + 1'b1;
      rh_d = col_q[0] ? rh_q : bus.i_data;
      lb_we = col_q[0] & ~row_q[0];
      o_ce_d = col_q[0] & row_q[0];
      o_data_d = o_ce_d ? win : '0;
      o_fd_d = o_ce_d & col_last & row_last;
    end
  end
  always_ff @(posedge clk or negedge global_rst_n)
    if (!global_rst_n) begin
      col_q <= '0;
      row_q <= '0;
      rh_q <= '0;
      o_data_q <= '0;
      o_ce_q <= 1'b0;
      o_fd_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      rh_q <= rh_d;
      o_data_q <= o_data_d;
      o_ce_q <= o_ce_d;
      o_fd_q <= o_fd_d;
    end
  assign bus.o_data = o_data_q;
  assign bus.o_ce = o_ce_q;
  assign bus.o_frame_done = o_fd_q;
endmodule

// File: tb/tb_max_pool_2x2.sv
// tb_max_pool_2x2: directed checks of the 4x4 pooling stream (max build, or average with MAX_POOL_AVG_EN)
module tb_max_pool_2x2;
  typedef logic signed [31:0] px_t;
  typedef px_t frame_t [16];
  typedef px_t outs_t [4];
  logic clk = 1'b0;
  logic global_rst_n = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  max_pool_2x2_if #(.BIT_WIDTH(32)) bus();
  max_pool_2x2 #(.BIT_WIDTH(32), .IMG_W(4), .IMG_H(4)) dut (
    .clk(clk),
    .global_rst_n(global_rst_n),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input px_t obs, input px_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask
  task automatic outs(input string tag, input bit ec, input px_t ed, input bit ef);
    chk({tag, ".o_ce"}, px_t'(bus.o_ce), px_t'(ec));
    chk({tag, ".o_data"}, bus.o_data, ed);
    chk({tag, ".o_frame_done"}, px_t'(bus.o_frame_done), px_t'(ef));
  endtask
  task automatic push(input string tag, input px_t v, input bit ec, input px_t ed, input bit ef);
    bus.ce = 1'b1;
    bus.i_data = v;
    @(posedge clk);
    #1;
    bus.ce = 1'b0;
    bus.i_data = '0;
    outs(tag, ec, ed, ef);
  endtask
  task automatic idle(input string tag);
    @(posedge clk);
    #1;
    outs({tag, ".idle"}, 1'b0, '0, 1'b0);
  endtask
  task automatic run(input string tag, input frame_t p, input outs_t e, input bit gaps, input int n = 16);
    for (int i = 0; i < n; i++) begin
      int k;
      if (gaps)
        for (int g = 0; g < 3 && $urandom_range(0, 99) < 60; g++) idle(tag);
      k = (i == 5) ? 0 : (i == 7) ? 1 : (i == 13) ? 2 : (i == 15) ? 3 : -1;
      push($sformatf("%s[%0d]", tag, i), p[i], k >= 0, (k >= 0) ? e[k] : px_t'(0), i == 15);
    end
  endtask
  initial begin
    frame_t ramp, sgn, avg;
    outs_t e_ramp, e_sgn, e_avg;
    for (int i = 0; i < 16; i++) ramp[i] = px_t'(i);
    e_ramp = '{5, 7, 13, 15};
    sgn = '{-8, -3, 0, 0, -20, -1, 0, 0, 5, -100, 32'sh7fffffff, 32'sh80000000, 9, 4, -1, 3};
    e_sgn = '{-1, 0, 9, 32'sh7fffffff};
    avg = '{1, 2, -1, -2, 3, 5, -1, -1, 32'sh7fffffff, 32'sh7fffffff, 0, 0, 32'sh7fffffff, 32'sh7fffffff, 0, 0};
    e_avg = '{2, -2, 32'sh7fffffff, 0};
    bus.ce = 1'b0;
    bus.i_data = '0;
    #12;
    outs("por", 1'b0, '0, 1'b0);
    @(negedge clk);
    global_rst_n = 1'b1;
    idle("post_por");
`ifdef MAX_POOL_AVG_EN
    run("avg", avg, e_avg, 1'b0);
    run("avg_gaps", avg, e_avg, 1'b1);
`else
    run("ramp", ramp, e_ramp, 1'b0);
    run("ramp_b2b", ramp, e_ramp, 1'b0);
    run("gaps", ramp, e_ramp, 1'b1);
    run("signed", sgn, e_sgn, 1'b0);
    run("pre_arst", ramp, e_ramp, 1'b0, 6);
    global_rst_n = 1'b0;
    #2;
    outs("async_rst", 1'b0, '0, 1'b0);
    @(negedge clk);
    global_rst_n = 1'b1;
    run("after_arst", ramp, e_ramp, 1'b0);
    run("f1", ramp, e_ramp, 1'b0);
    run("f2_part", sgn, e_sgn, 1'b0, 6);
    rst = 1'b1;
    bus.ce = 1'b1;
    bus.i_data = 999;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.ce = 1'b0;
    bus.i_data = '0;
    outs("sync_rst", 1'b0, '0, 1'b0);
    run("f2", sgn, e_sgn, 1'b0);
    run("f3_gaps", sgn, e_sgn, 1'b1);
`endif
    idle("tail");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
